eth_rst_seq: RTL and testbench
==============================

# eth_rst_seq

Parametrised multi-channel reset sequencer for the Ethernet clock domain. It filters the PLL lock indication, holds every downstream reset for a long power-up interval, then releases `N_CH` resets one at a time, with a fixed gap between releases. It re-runs the whole sequence on lock loss or on a soft-reset request. It sits directly after the clock wizard and drives the PHY reset pin plus the MAC/TX/RX reset trees.

## Interface
Parameters:
- `N_CH`, default 3: number of sequenced reset outputs; must be ≥1. Channel 0 is the PHY.
- `LOCK_FILT`, default 16: consecutive cycles synchronised lock must be high before the hold interval starts; must be ≥1.
- `WAIT_CYCLES`, default 2000000: hold interval after a filtered lock, before channel 0 releases (40 ms at 50 MHz); must be ≥1.
- `STEP_CYCLES`, default 1000: gap between release of channel i-1 and channel i; must be ≥1.

Ports:
- `clk`, input, 1: Ethernet-domain clock; all logic is on its rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `locked`, input, 1: PLL lock, asynchronous to `clk`.
- `soft_rst_req`, input, 1: synchronous single-cycle request to re-run the sequence.
- `rst_out`, output, `N_CH`: active-high resets, one per channel.
- `phy_rstn`, output, 1: equals `~rst_out[0]`, registered; drives the PHY pin.
- `done`, output, 1: high once all channels are released.
- `state`, output, 2: current FSM state, encoded IDLE=0, WAIT=1, STAGE=2, RUN=3.

## Operation
- `locked` passes through a 2-flop synchroniser, giving `lock_s`. Both flops reset to 0.
- All outputs are registered. While `rst` is high:
  - `rst_out` is all ones.
  - `phy_rstn` = 0, `done` = 0.
  - `state` = IDLE.
  - All counters are 0.
- **IDLE**: all channels asserted. The filter counter increments on every edge where `lock_s` = 1 and clears when `lock_s` = 0. When the count reaches `LOCK_FILT`, the FSM enters WAIT and the counter clears.
- **WAIT**: counts `WAIT_CYCLES` edges. On the final edge:
  - `rst_out[0]` ← 0.
  - The FSM goes to STAGE, or to RUN when `N_CH` = 1.
- **STAGE**: a step counter counts `STEP_CYCLES` edges, then the next channel index releases. Releasing channel `N_CH`-1 moves the FSM to RUN.
  - Released channels stay released. Release order is strictly ascending.
- **RUN**: all `rst_out` = 0, `done` = 1. The FSM holds here indefinitely.
- **Abort**: lock loss (`lock_s` = 0) or `soft_rst_req` = 1, sampled in WAIT, STAGE or RUN.
  - On that edge: `rst_out` ← all ones, `done` ← 0, `state` ← IDLE, all counters ← 0.
  - No filtering is applied on loss; a single low cycle on `lock_s` aborts.
- `soft_rst_req` in IDLE clears the filter counter.
- Simultaneous lock loss and soft request give the same single abort.
- Counter widths are `$clog2` of the respective maximum plus 1. Counters never wrap; each stops at its terminal value.

## Timing
- Edge numbering: edge 1 is the first rising edge after `rst` deasserts, with `locked` already stable high.
  - `lock_s` = 1 after edge 2.
  - State is WAIT after edge 2+`LOCK_FILT`.
  - `rst_out[0]` falls and `phy_rstn` rises after edge T0 = 2+`LOCK_FILT`+`WAIT_CYCLES`.
  - `rst_out[i]` falls after edge T0 + i·`STEP_CYCLES`.
  - `done` rises on the same edge as `rst_out[N_CH-1]` falls.
- Lock-loss latency: if `locked` falls between edges k-1 and k, `rst_out` is all ones after edge k+2.
- Soft-request latency: `soft_rst_req` high at edge k gives `rst_out` all ones after edge k.
- Asynchronous `rst` forces all outputs to reset values immediately, mid-sequence included. The full sequence restarts from IDLE on deassertion.

## Test plan
- **Nominal sequence**: `N_CH`=3, `LOCK_FILT`=4, `WAIT_CYCLES`=20, `STEP_CYCLES`=5; `locked` high before `rst` drops.
  - `rst_out[0]` falls after edge 26, `rst_out[1]` after edge 31, `rst_out[2]` after edge 36.
  - `done` = 1 after edge 36; `state` = 3.
- **Filter glitch**: same parameters, `locked` low for 1 cycle at edge 4.
  - Filter restarts; every release edge shifts later by the lost cycles; no channel releases early.
- **Lock loss**:
  - In STAGE after channel 1 releases: `locked` low → all `rst_out` = 1 within 3 edges, `done` = 0, `state` = 0.
  - Restoring `locked` then repeats the nominal timing relative to the new lock.
- **Soft reset**: in RUN, `soft_rst_req` pulse at edge k.
  - `rst_out` = 3'b111 after edge k.
  - `rst_out[0]` falls after edge k+`LOCK_FILT`+`WAIT_CYCLES`.
- **Async reset mid-WAIT**: assert `rst` between edges → `rst_out`, `phy_rstn`, `done` and `state` take reset values with no clock edge.
- **Degenerate**: `N_CH`=1, `STEP_CYCLES`=1 → FSM goes WAIT→RUN directly, and `done` and `rst_out[0]` change on the same edge.

Source files
------------

// File: rtl/eth_rst_seq.sv
// eth_rst_seq: filters PLL lock, holds resets for a power-up interval, then releases
// N_CH channel resets in ascending order with a fixed gap; re-runs on lock loss or soft request.
module eth_rst_seq #(
    parameter int N_CH        = 3,
    parameter int LOCK_FILT   = 16,
    parameter int WAIT_CYCLES = 2000000,
    parameter int STEP_CYCLES = 1000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            locked,
    input  logic            soft_rst_req,
    output logic [N_CH-1:0] rst_out,
    output logic            phy_rstn,
    output logic            done,
    output logic [1:0]      state
);
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, STAGE = 2'd2, RUN = 2'd3} state_t;

    localparam int FW = $clog2(LOCK_FILT) + 1;
    localparam int WW = $clog2(WAIT_CYCLES) + 1;
    localparam int SW = $clog2(STEP_CYCLES) + 1;
    localparam int CW = $clog2(N_CH) + 1;
    localparam logic [FW-1:0] FILT_LAST = FW'(LOCK_FILT - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_CYCLES - 1);
    localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);
    localparam logic [CW-1:0] CH_LAST   = CW'(N_CH - 1);

    logic [1:0]      sync;
    logic            lock_s;
    state_t          st, st_d;
    logic [FW-1:0]   filt_cnt, filt_d;
    logic [WW-1:0]   wait_cnt, wait_d;
    logic [SW-1:0]   step_cnt, step_d;
    logic [CW-1:0]   ch_idx, ch_d;
    logic [N_CH-1:0] rst_out_d;
    logic            done_d;
    logic            abort;

    assign lock_s = sync[1];
    assign state  = st;
    // A single low synchronised lock cycle or a soft request restarts everything.
    assign abort  = (st != IDLE) && (!lock_s || soft_rst_req);

    always_comb begin
        st_d      = st;
        filt_d    = filt_cnt;
        wait_d    = wait_cnt;
        step_d    = step_cnt;
        ch_d      = ch_idx;
        rst_out_d = rst_out;
        done_d    = done;
        if (abort) begin
            st_d      = IDLE;
            filt_d    = '0;
            wait_d    = '0;
            step_d    = '0;
            ch_d      = '0;
            rst_out_d = '1;
            done_d    = 1'b0;
        end else begin
            case (st)
                IDLE: begin
                    rst_out_d = '1;
                    done_d    = 1'b0;
                    filt_d    = (!lock_s || soft_rst_req || filt_cnt == FILT_LAST) ? '0 : filt_cnt + 1'b1;
                    st_d      = (lock_s && !soft_rst_req && filt_cnt == FILT_LAST) ? WAIT : IDLE;
                end
                WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        wait_d       = '0;
                        rst_out_d[0] = 1'b0;
                        ch_d         = CW'(1);
                        st_d         = (N_CH == 1) ? RUN : STAGE;
                        done_d       = (N_CH == 1);
                    end else begin
                        wait_d = wait_cnt + 1'b1;
                    end
                end
                STAGE: begin
                    if (step_cnt == STEP_LAST) begin
                        step_d    = '0;
                        rst_out_d = rst_out & ~(N_CH'(1) << ch_idx);
                        ch_d      = (ch_idx == CH_LAST) ? ch_idx : ch_idx + 1'b1;
                        st_d      = (ch_idx == CH_LAST) ? RUN : STAGE;
                        done_d    = (ch_idx == CH_LAST);
                    end else begin
                        step_d = step_cnt + 1'b1;
                    end
                end
                RUN: begin
                    rst_out_d = '0;
                    done_d    = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync     <= 2'b00;
            st       <= IDLE;
            filt_cnt <= '0;
            wait_cnt <= '0;
            step_cnt <= '0;
            ch_idx   <= '0;
            rst_out  <= '1;
            done     <= 1'b0;
            phy_rstn <= 1'b0;
        end else begin
            sync     <= {sync[0], locked};
            st       <= st_d;
            filt_cnt <= filt_d;
            wait_cnt <= wait_d;
            step_cnt <= step_d;
            ch_idx   <= ch_d;
            rst_out  <= rst_out_d;
            done     <= done_d;
            phy_rstn <= ~rst_out_d[0];
        end
    end
endmodule

// File: tb/tb_eth_rst_seq.sv
// tb_eth_rst_seq: directed checks of a 3-channel sequencer and a 1-channel degenerate instance
// sharing clock and inputs.
module tb_eth_rst_seq;
    logic       clk = 1'b0;
    logic       rst;
    logic       locked;
    logic       soft_rst_req;
    logic [2:0] rst_out;
    logic       phy_rstn;
    logic       done;
    logic [1:0] state;
    logic [0:0] rst_out1;
    logic       phy_rstn1;
    logic       done1;
    logic [1:0] state1;
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    eth_rst_seq #(.N_CH(3), .LOCK_FILT(4), .WAIT_CYCLES(20), .STEP_CYCLES(5)) dut (
        .clk(clk), .rst(rst), .locked(locked), .soft_rst_req(soft_rst_req),
        .rst_out(rst_out), .phy_rstn(phy_rstn), .done(done), .state(state)
    );

    eth_rst_seq #(.N_CH(1), .LOCK_FILT(4), .WAIT_CYCLES(20), .STEP_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .locked(locked), .soft_rst_req(soft_rst_req),
        .rst_out(rst_out1), .phy_rstn(phy_rstn1), .done(done1), .state(state1)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [2:0] ro, input logic pr, input logic dn, input logic [1:0] st);
        chk({tag, ".rst_out"}, 32'(rst_out), 32'(ro));
        chk({tag, ".phy_rstn"}, 32'(phy_rstn), 32'(pr));
        chk({tag, ".done"}, 32'(done), 32'(dn));
        chk({tag, ".state"}, 32'(state), 32'(st));
    endtask

    initial begin
        rst = 1'b1;
        locked = 1'b1;
        soft_rst_req = 1'b0;
        tick(3);
        chk_all("reset", 3'b111, 1'b0, 1'b0, 2'd0);
        chk("reset.deg_rst_out", 32'(rst_out1), 32'd1);
        rst = 1'b0;
        // Nominal: edges counted from the first edge after rst release.
        tick(5);
        chk("nom.e5.state", 32'(state), 32'd0);
        tick(1);
        chk("nom.e6.state", 32'(state), 32'd1);
        tick(19);
        chk_all("nom.e25", 3'b111, 1'b0, 1'b0, 2'd1);
        chk("nom.e25.deg_rst_out", 32'(rst_out1), 32'd1);
        chk("nom.e25.deg_done", 32'(done1), 32'd0);
        tick(1);
        chk_all("nom.e26", 3'b110, 1'b1, 1'b0, 2'd2);
        chk("nom.e26.deg_rst_out", 32'(rst_out1), 32'd0);
        chk("nom.e26.deg_done", 32'(done1), 32'd1);
        chk("nom.e26.deg_state", 32'(state1), 32'd3);
        chk("nom.e26.deg_phy", 32'(phy_rstn1), 32'd1);
        tick(4);
        chk("nom.e30.rst_out", 32'(rst_out), 32'b110);
        tick(1);
        chk("nom.e31.rst_out", 32'(rst_out), 32'b100);
        tick(4);
        chk_all("nom.e35", 3'b100, 1'b1, 1'b0, 2'd2);
        tick(1);
        chk_all("nom.e36", 3'b000, 1'b1, 1'b1, 2'd3);
        // Soft request sampled at edge 41.
        tick(4);
        soft_rst_req = 1'b1;
        tick(1);
        soft_rst_req = 1'b0;
        chk_all("soft.e41", 3'b111, 1'b0, 1'b0, 2'd0);
        chk("soft.e41.deg_done", 32'(done1), 32'd0);
        tick(23);
        chk("soft.e64.rst_out", 32'(rst_out), 32'b111);
        tick(1);
        chk_all("soft.e65", 3'b110, 1'b1, 1'b0, 2'd2);
        tick(5);
        chk("loss.e70.rst_out", 32'(rst_out), 32'b100);
        // Lock drops between edges 71 and 72: abort visible after edge 74.
        tick(1);
        locked = 1'b0;
        tick(2);
        chk("loss.e73.rst_out", 32'(rst_out), 32'b100);
        chk("loss.e73.state", 32'(state), 32'd2);
        tick(1);
        chk_all("loss.e74", 3'b111, 1'b0, 1'b0, 2'd0);
        chk("loss.e74.deg_rst_out", 32'(rst_out1), 32'd1);
        tick(2);
        locked = 1'b1;
        // Lock returns between edges 76 and 77: timing repeats with edge 77 as new edge 1.
        tick(25);
        chk("relock.e101.rst_out", 32'(rst_out), 32'b111);
        tick(1);
        chk_all("relock.e102", 3'b110, 1'b1, 1'b0, 2'd2);
        tick(5);
        chk("relock.e107.rst_out", 32'(rst_out), 32'b100);
        tick(5);
        chk_all("relock.e112", 3'b000, 1'b1, 1'b1, 2'd3);
        // Soft request at edge 113 then async reset mid-WAIT.
        soft_rst_req = 1'b1;
        tick(1);
        soft_rst_req = 1'b0;
        tick(7);
        chk("async.wait.state_before", 32'(state), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk_all("async.wait", 3'b111, 1'b0, 1'b0, 2'd0);
        // Filter glitch: locked low across edge 4 of a fresh sequence.
        tick(2);
        rst = 1'b0;
        tick(3);
        locked = 1'b0;
        tick(1);
        locked = 1'b1;
        tick(2);
        chk("glitch.e6.state", 32'(state), 32'd0);
        tick(3);
        chk("glitch.e9.state", 32'(state), 32'd0);
        tick(1);
        chk("glitch.e10.state", 32'(state), 32'd1);
        tick(19);
        chk_all("glitch.e29", 3'b111, 1'b0, 1'b0, 2'd1);
        tick(1);
        chk_all("glitch.e30", 3'b110, 1'b1, 1'b0, 2'd2);
        tick(5);
        chk("glitch.e35.rst_out", 32'(rst_out), 32'b100);
        tick(5);
        chk_all("glitch.e40", 3'b000, 1'b1, 1'b1, 2'd3);
        // Async reset in RUN takes effect without a clock edge.
        #3 rst = 1'b1;
        #1;
        chk_all("async.run", 3'b111, 1'b0, 1'b0, 2'd0);
        chk("async.run.deg_done", 32'(done1), 32'd0);
        chk("async.run.deg_rst_out", 32'(rst_out1), 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
